// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream, BRAM port-A override and boot status bundle for imem_loader
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        boot_req;
  logic        load_active;
  logic [31:0] load_addr;
  logic [31:0] load_di;
  logic [3:0]  load_we;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  modport slave (
    input  rx_valid, rx_data, boot_req,
    output rx_ready, load_active, load_addr, load_di, load_we, cpu_rst_n, done, error
  );

  modport master (
    output rx_valid, rx_data, boot_req,
    input  rx_ready, load_active, load_addr, load_di, load_we, cpu_rst_n, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: framed byte stream to BRAM words, checksum-gated core reset
module imem_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  state_t         r_state, w_next;
  logic [23:0]    r_shift;
  logic [1:0]     r_bcnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_n;
  logic [7:0]     r_sum;
  logic [3:0]     r_we;
  logic [31:0]    r_addr;
  logic [31:0]    r_di;

  logic           w_rx_ready;
  logic           w_xfer;
  logic [31:0]    w_word;
  logic           w_bad_n;
  logic           w_last_word;
  logic [31:0]    w_addr;

  assign w_rx_ready  = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_xfer      = bus.rx_valid && w_rx_ready;
  // The shift register holds the three earlier bytes, so header and data words complete on the 4th byte.
  assign w_word      = {bus.rx_data, r_shift};
  assign w_bad_n     = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));
  assign w_last_word = ((r_idx + IDX_W'(1)) == r_n);
  assign w_addr      = BASE_ADDR + (32'(r_idx) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR:  if (w_xfer && r_bcnt == 2'd3) w_next = w_bad_n ? S_ERR : S_DATA;
      S_DATA: if (w_xfer && r_bcnt == 2'd3 && w_last_word) w_next = S_CSUM;
      S_CSUM: if (w_xfer) w_next = (bus.rx_data == r_sum) ? S_RUN : S_ERR;
      S_RUN,
      S_ERR:  if (bus.boot_req) w_next = S_HDR;
      default: w_next = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_n     <= '0;
      r_sum   <= '0;
      r_we    <= 4'h0;
      r_addr  <= '0;
      r_di    <= '0;
    end else begin
      r_we <= 4'h0;
      if (w_xfer) begin
        r_shift <= {bus.rx_data, r_shift[23:8]};
        r_bcnt  <= r_bcnt + 2'd1;
      end
      case (r_state)
        S_HDR: begin
          if (w_xfer && r_bcnt == 2'd3) begin
            r_n   <= w_word[IDX_W-1:0];
            r_idx <= '0;
            r_sum <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_sum <= r_sum + bus.rx_data;
            if (r_bcnt == 2'd3) begin
              r_we   <= 4'hF;
              r_addr <= w_addr;
              r_di   <= w_word;
              r_idx  <= r_idx + IDX_W'(1);
            end
          end
        end
        S_RUN,
        S_ERR: begin
          if (bus.boot_req) begin
            r_bcnt <= '0;
            r_idx  <= '0;
            r_sum  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs are pure state decodes so a reload drops cpu_rst_n the cycle HDR is entered.
  assign bus.rx_ready    = w_rx_ready;
  assign bus.load_active = (r_state != S_RUN);
  assign bus.cpu_rst_n   = (r_state == S_RUN);
  assign bus.done        = (r_state == S_RUN);
  assign bus.error       = (r_state == S_ERR);
  assign bus.load_we     = r_we;
  assign bus.load_addr   = r_addr;
  assign bus.load_di     = r_di;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader framing, limits, reload and reset abort
module tb_imem_loader;
  localparam int          MAXW = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if lif();

  imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lif.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [31:0] payload[$];
  logic [31:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && lif.load_we !== 4'h0) begin
      check("we_full", 32'(lif.load_we), 32'hF);
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(lif.load_we), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", lif.load_addr, e.addr);
        check("wr_data", lif.load_di, e.data);
      end
      last_addr = lif.load_addr;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      lif.rx_valid = 1'b0;
      lif.boot_req = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic br);
    int t = 0;
    @(negedge clk);
    while (!lif.rx_ready && t < 50) begin
      lif.rx_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (!lif.rx_ready) check("rx_ready_timeout", 32'(lif.rx_ready), 32'h1);
    lif.rx_valid = 1'b1;
    lif.rx_data  = b;
    lif.boot_req = br;
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] n_hdr, input int csum_delta, input bit throttle,
                            input int pulse_at, input int abort_after);
    logic [7:0] bytes[$];
    logic [7:0] sum = 8'h00;
    int         np;
    np = payload.size();
    for (int k = 0; k < 4; k++) bytes.push_back(n_hdr[8*k +: 8]);
    for (int w = 0; w < np; w++) begin
      for (int k = 0; k < 4; k++) begin
        bytes.push_back(payload[w][8*k +: 8]);
        sum = sum + payload[w][8*k +: 8];
      end
    end
    if (np > 0) bytes.push_back(sum + 8'(csum_delta));
    for (int i = 0; i < bytes.size(); i++) begin
      if (abort_after >= 0 && i == 4 + abort_after) break;
      if (throttle) idle($urandom_range(0, 5));
      if (i >= 4 && i < 4 + 4*np && ((i - 4) % 4) == 3)
        exp_q.push_back('{BASE + 32'(4 * ((i - 4) / 4)), payload[(i - 4) / 4]});
      send_byte(bytes[i], (i == pulse_at));
    end
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(lif.done || lif.error) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!(lif.done || lif.error)) check("end_timeout", 32'(lif.done | lif.error), 32'h1);
  endtask

  task automatic expect_run(input string tag);
    wait_end();
    check({tag, "_done"}, 32'(lif.done), 32'h1);
    check({tag, "_cpu_rst_n"}, 32'(lif.cpu_rst_n), 32'h1);
    check({tag, "_load_active"}, 32'(lif.load_active), 32'h0);
    check({tag, "_rx_ready"}, 32'(lif.rx_ready), 32'h0);
    check({tag, "_error"}, 32'(lif.error), 32'h0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic expect_err(input string tag);
    wait_end();
    check({tag, "_error"}, 32'(lif.error), 32'h1);
    check({tag, "_cpu_rst_n"}, 32'(lif.cpu_rst_n), 32'h0);
    check({tag, "_rx_ready"}, 32'(lif.rx_ready), 32'h0);
    check({tag, "_done"}, 32'(lif.done), 32'h0);
    check({tag, "_load_active"}, 32'(lif.load_active), 32'h1);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic reload(input string tag);
    @(negedge clk);
    lif.boot_req = 1'b1;
    @(negedge clk);
    lif.boot_req = 1'b0;
    check({tag, "_cpu_rst_n"}, 32'(lif.cpu_rst_n), 32'h0);
    check({tag, "_done"}, 32'(lif.done), 32'h0);
    check({tag, "_error"}, 32'(lif.error), 32'h0);
    check({tag, "_rx_ready"}, 32'(lif.rx_ready), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(lif.rx_ready), 32'h1);
    check({tag, "_load_active"}, 32'(lif.load_active), 32'h1);
    check({tag, "_load_we"}, 32'(lif.load_we), 32'h0);
    check({tag, "_load_addr"}, lif.load_addr, 32'h0);
    check({tag, "_load_di"}, lif.load_di, 32'h0);
    check({tag, "_cpu_rst_n"}, 32'(lif.cpu_rst_n), 32'h0);
    check({tag, "_done"}, 32'(lif.done), 32'h0);
    check({tag, "_error"}, 32'(lif.error), 32'h0);
  endtask

  initial begin
    lif.rx_valid = 1'b0;
    lif.rx_data  = 8'h00;
    lif.boot_req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    payload = '{32'h0000_0013, 32'h0010_0093};
    send_frame(32'd2, 0, 1'b0, -1, -1);
    idle(1);
    expect_run("good");

    // Bytes offered while running must not be taken.
    repeat (3) begin
      @(negedge clk);
      lif.rx_valid = 1'b1;
      lif.rx_data  = 8'hAA;
    end
    idle(1);
    check("run_extra_done", 32'(lif.done), 32'h1);

    reload("reload1");
    payload = '{32'hDEAD_BEEF, 32'h1234_5678};
    send_frame(32'd2, 0, 1'b0, 6, -1);
    idle(1);
    expect_run("overwrite");

    reload("reload2");
    payload = '{32'h0000_0013, 32'h0010_0093};
    send_frame(32'd2, 1, 1'b0, -1, -1);
    idle(1);
    expect_err("badsum");

    reload("reload3");
    payload = {};
    send_frame(32'd0, 0, 1'b0, -1, -1);
    idle(2);
    expect_err("n_zero");

    reload("reload4");
    send_frame(32'(MAXW + 1), 0, 1'b0, -1, -1);
    idle(2);
    expect_err("n_over");

    reload("reload5");
    payload = {};
    for (int w = 0; w < MAXW; w++) payload.push_back($urandom);
    send_frame(32'(MAXW), 0, 1'b0, -1, -1);
    idle(1);
    expect_run("n_max");
    check("n_max_last_addr", last_addr, BASE + 32'(4 * (MAXW - 1)));

    reload("reload6");
    payload = '{32'h0000_0013, 32'h0010_0093};
    send_frame(32'd2, 0, 1'b1, -1, -1);
    idle(1);
    expect_run("throttled");

    reload("reload7");
    send_frame(32'd2, 0, 1'b0, -1, 5);
    @(negedge clk);
    rst_n = 1'b0;
    lif.rx_valid = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_pending", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(32'd2, 0, 1'b0, -1, -1);
    idle(1);
    expect_run("after_abort");

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller that sequences program loading into the instruction/data BRAM before the pipeline runs. It accepts a framed byte stream (typically from a UART receiver), assembles little-endian words and issues one full-word write per word through a port-A override. It holds the CPU core in reset until the image is verified by checksum, and can re-enter load mode on request. It sits between the UART front end, the BRAM port-A address/data/write-enable mux, and the core's `rst_n`.

## Interface

- `MAX_WORDS`, default 1024: largest accepted image in 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be word-aligned.

- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers when `rx_valid & rx_ready` at a rising edge.
- `boot_req`  in  1  request reload; sampled only in RUN or ERR.
- `load_active`  out  1  when 1, the top-level mux routes `load_addr`/`load_di`/`load_we` to BRAM port A instead of `IF_pc`.
- `load_addr`  out  32  BRAM byte address.
- `load_di`  out  32  BRAM write data.
- `load_we`  out  4  byte write enables; only 4'h0 or 4'hF.
- `cpu_rst_n`  out  1  active-low reset to the core; 0 except in RUN.
- `done`  out  1  image loaded and verified.
- `error`  out  1  header or checksum failure.

## Operation

- Frame format: 4-byte word count N (little-endian), then 4·N payload bytes (each word little-endian), then 1 checksum byte equal to the 8-bit sum mod 256 of all payload bytes. Header bytes are excluded from the sum.
- States:
  - HDR: collect 4 header bytes. After the 4th byte: if N==0 or N>MAX_WORDS, go to ERR; else clear the word index, byte counter and sum, then go to DATA.
  - DATA: accept bytes into a shift register and add each to the 8-bit sum. On the 4th byte of a word, register a write, increment the word index, and go to CSUM once the index equals N.
  - CSUM: accept 1 byte. Go to RUN if it equals the sum, else go to ERR.
  - RUN: `cpu_rst_n`=1, `load_active`=0, `done`=1, `rx_ready`=0. `boot_req`=1 goes to HDR.
  - ERR: `error`=1, `cpu_rst_n`=0, `load_active`=1, `rx_ready`=0. `boot_req`=1 goes to HDR.
- `rx_ready` is 1 in HDR, DATA and CSUM, decoded from the state register.
- Write address is BASE_ADDR + 4·index, using 32-bit wrap arithmetic. The index is ceil(log2(MAX_WORDS+1)) bits.
- Entering HDR from RUN or ERR clears `done`, `error`, the counters and the sum, and drives `cpu_rst_n` to 0.
- `boot_req` is ignored in HDR, DATA and CSUM. Extra bytes presented in RUN or ERR are not consumed.

## Timing

- Reset values: state=HDR, `rx_ready`=1, `load_active`=1, `load_we`=0, `load_addr`=0, `load_di`=0, `cpu_rst_n`=0, `done`=0, `error`=0. Asynchronous reset mid-DATA or mid-CSUM aborts the load immediately; `load_we` drops to 0 without waiting for a clock.
- Write latency: `load_we`=4'hF, `load_addr` and `load_di` are valid for exactly one cycle, the cycle after the edge that accepted the word's 4th byte. `load_we` is 0 at all other times.
- Back-to-back bytes at one per cycle are supported with no stall. `rx_ready` never deasserts inside DATA.
- Transfer to RUN or ERR happens at the edge after the checksum byte is accepted, or after the 4th header byte on a bad N. Outputs change in the following cycle, and the last word's write pulse has completed by then.
- `boot_req` in RUN or ERR: state=HDR and `cpu_rst_n`=0 one cycle after the sampling edge.
- All outputs are registered or state-decoded; there is no combinational path from inputs to outputs.

## Test plan

- Good image: N=2, payload 13 00 00 00 93 00 10 00, checksum B6.
  - Required: writes {addr 0, data 0x00000013} then {addr 4, data 0x00100093}, each with `load_we`=F for 1 cycle.
  - Then `done`=1, `cpu_rst_n`=1, `load_active`=0.
- Bad checksum: same frame with checksum B7.
  - Required: both writes still occur, then `error`=1, `cpu_rst_n`=0, `rx_ready`=0, `done`=0.
- Header limits: N=0, and separately N=MAX_WORDS+1.
  - Required: ERR after the 4th header byte, with no write pulses.
  - Separately, N=MAX_WORDS: the last write lands at BASE_ADDR+4·(MAX_WORDS−1).
- Throttled input: the good image with random 0–5 cycle `rx_valid` gaps.
  - Required: writes and final state are identical to the back-to-back case.
- Reset mid-DATA: assert `rst_n`=0 after 5 payload bytes.
  - Required: outputs return to their reset values immediately, with no spurious write.
  - Then a fresh good frame loads correctly.
- Reload: `boot_req`=1 in RUN.
  - Required: `cpu_rst_n`=0 and `done`=0 next cycle, and `rx_ready`=1.
  - A second image then overwrites addresses 0 and 4.
  - `boot_req` pulsed during DATA has no effect.
